// File: rtl/ula_controle.sv
// Sequencer for a 4-bit ALU: captures operands A and B from a strobed bus, runs one
// execute cycle, then holds the registered result until the consumer acknowledges it.
module ula_controle #(
    parameter int CONT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        dado,
    input  logic [2:0]        op,
    input  logic              dado_valido,
    input  logic              ack,
    output logic [3:0]        A,
    output logic [3:0]        B,
    output logic [2:0]        seletor,
    input  logic [3:0]        resultado_in,
    input  logic              carry_in,
    output logic [3:0]        resultado,
    output logic              carry,
    output logic              zero,
    output logic              saida_valida,
    output logic              ocupado,
    output logic [CONT_W-1:0] contador
);

    typedef enum logic [1:0] {
        ESPERA_A = 2'd0,
        ESPERA_B = 2'd1,
        EXECUTA  = 2'd2,
        PRONTO   = 2'd3
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [3:0]        a_q, a_d;
    logic [3:0]        b_q, b_d;
    logic [2:0]        sel_q, sel_d;
    logic [3:0]        res_q, res_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;
    logic              valid_q, valid_d;
    logic              ocupado_q, ocupado_d;
    logic [CONT_W-1:0] cont_q, cont_d;

    // Next-state and datapath update logic
    always_comb begin
        estado_d  = estado_q;
        a_d       = a_q;
        b_d       = b_q;
        sel_d     = sel_q;
        res_d     = res_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        valid_d   = valid_q;
        cont_d    = cont_q;
        case (estado_q)
            ESPERA_A: begin
                if (dado_valido) begin
                    a_d      = dado;
                    estado_d = ESPERA_B;
                end else begin
                    estado_d = ESPERA_A;
                end
            end
            ESPERA_B: begin
                if (dado_valido) begin
                    b_d      = dado;
                    sel_d    = op;
                    estado_d = EXECUTA;
                end else begin
                    estado_d = ESPERA_B;
                end
            end
            EXECUTA: begin
                res_d    = resultado_in;
                carry_d  = carry_in;
                zero_d   = (resultado_in == 4'b0000);
                cont_d   = cont_q + CONT_W'(1);
                valid_d  = 1'b1;
                estado_d = PRONTO;
            end
            PRONTO: begin
                // dado_valido is deliberately ignored here, even together with ack
                if (ack) begin
                    valid_d  = 1'b0;
                    estado_d = ESPERA_A;
                end else begin
                    estado_d = PRONTO;
                end
            end
            default: begin
                estado_d = ESPERA_A;
            end
        endcase
        ocupado_d = (estado_d == EXECUTA) || (estado_d == PRONTO);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q  <= ESPERA_A;
            a_q       <= 4'h0;
            b_q       <= 4'h0;
            sel_q     <= 3'b000;
            res_q     <= 4'h0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b1;
            valid_q   <= 1'b0;
            ocupado_q <= 1'b0;
            cont_q    <= '0;
        end else begin
            estado_q  <= estado_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sel_q     <= sel_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
            valid_q   <= valid_d;
            ocupado_q <= ocupado_d;
            cont_q    <= cont_d;
        end
    end

    assign A            = a_q;
    assign B            = b_q;
    assign seletor      = sel_q;
    assign resultado    = res_q;
    assign carry        = carry_q;
    assign zero         = zero_q;
    assign saida_valida = valid_q;
    assign ocupado      = ocupado_q;
    assign contador     = cont_q;

endmodule

// File: tb/tb_ula_controle.sv
// Scoreboard bench for ula_controle with a small combinational 4-bit ALU model attached.
module tb_ula_controle;

    logic       clk;
    logic       reset;
    logic [3:0] dado;
    logic [2:0] op;
    logic       dado_valido;
    logic       ack;
    logic [3:0] A_s, B_s, resultado_s, resultado_in_s;
    logic [2:0] sel_s;
    logic       carry_in_s, carry_s, zero_s, valido_s, ocupado_s;
    logic [7:0] contador_s;
    logic [4:0] alu_s;

    typedef struct {
        logic [3:0] res;
        logic       c;
        logic       z;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       e;
    logic [7:0] exp_cnt;
    logic       valido_prev;
    int         checks;
    int         errors;

    ula_controle #(.CONT_W(8)) dut (
        .clk(clk), .reset(reset), .dado(dado), .op(op), .dado_valido(dado_valido),
        .ack(ack), .A(A_s), .B(B_s), .seletor(sel_s), .resultado_in(resultado_in_s),
        .carry_in(carry_in_s), .resultado(resultado_s), .carry(carry_s), .zero(zero_s),
        .saida_valida(valido_s), .ocupado(ocupado_s), .contador(contador_s)
    );

    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        case (s)
            3'b000:  alu_f = {1'b0, a & b};
            3'b001:  alu_f = {1'b0, a | b};
            3'b010:  alu_f = {1'b0, a} + {1'b0, b};
            3'b011:  alu_f = {1'b0, a ^ b};
            3'b110:  alu_f = {1'b0, a} + {1'b0, ~b} + 5'd1;
            default: alu_f = {1'b0, a};
        endcase
    endfunction

    assign alu_s          = alu_f(A_s, B_s, sel_s);
    assign resultado_in_s = alu_s[3:0];
    assign carry_in_s     = alu_s[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: compare each newly presented result against the scoreboard
    always @(negedge clk) begin
        if (valido_s === 1'b1 && valido_prev === 1'b0) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected none", resultado_s);
            end else begin
                e = sb_q.pop_front();
                chk("resultado", {28'd0, resultado_s}, {28'd0, e.res});
                chk("carry", {31'd0, carry_s}, {31'd0, e.c});
                chk("zero", {31'd0, zero_s}, {31'd0, e.z});
                chk("contador", {24'd0, contador_s}, {24'd0, e.cnt});
            end
        end
        valido_prev = valido_s;
    end

    task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] o,
                          input logic [3:0] er, input logic ec, input logic ez);
        @(negedge clk);
        dado = a; dado_valido = 1'b1;
        @(negedge clk);
        chk("A_load", {28'd0, A_s}, {28'd0, a});
        dado = b; op = o; dado_valido = 1'b1;
        exp_cnt = exp_cnt + 8'd1;
        sb_q.push_back('{res: er, c: ec, z: ez, cnt: exp_cnt});
        @(negedge clk);
        dado_valido = 1'b0;
        chk("B_load", {28'd0, B_s}, {28'd0, b});
        chk("sel_load", {29'd0, sel_s}, {29'd0, o});
        chk("ocupado_exec", {31'd0, ocupado_s}, 32'd1);
        chk("valid_early", {31'd0, valido_s}, 32'd0);
        @(negedge clk);
        chk("latency", {31'd0, valido_s}, 32'd1);
    endtask

    task automatic do_ack();
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("valid_after_ack", {31'd0, valido_s}, 32'd0);
        chk("ocupado_after_ack", {31'd0, ocupado_s}, 32'd0);
    endtask

    initial begin
        checks = 0; errors = 0; exp_cnt = 8'd0; valido_prev = 1'b0;
        reset = 1'b1; dado = 4'h0; op = 3'b000; dado_valido = 1'b0; ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_A", {28'd0, A_s}, 32'd0);
        chk("rst_B", {28'd0, B_s}, 32'd0);
        chk("rst_sel", {29'd0, sel_s}, 32'd0);
        chk("rst_res", {28'd0, resultado_s}, 32'd0);
        chk("rst_carry", {31'd0, carry_s}, 32'd0);
        chk("rst_zero", {31'd0, zero_s}, 32'd1);
        chk("rst_valid", {31'd0, valido_s}, 32'd0);
        chk("rst_ocupado", {31'd0, ocupado_s}, 32'd0);
        chk("rst_cont", {24'd0, contador_s}, 32'd0);
        reset = 1'b0;

        // Add with carry out, then subtraction to zero and with borrow
        run_op(4'h9, 4'h8, 3'b010, 4'h1, 1'b1, 1'b0);
        do_ack();
        run_op(4'h5, 4'h5, 3'b110, 4'h0, 1'b1, 1'b1);
        do_ack();
        run_op(4'h3, 4'h5, 3'b110, 4'hE, 1'b0, 1'b0);

        // Hold in PRONTO without ack while strobing data
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            dado = 4'hF; dado_valido = (i % 2 == 0);
            chk("hold_res", {28'd0, resultado_s}, 32'hE);
            chk("hold_valid", {31'd0, valido_s}, 32'd1);
            chk("hold_A", {28'd0, A_s}, 32'h3);
            chk("hold_cont", {24'd0, contador_s}, 32'd3);
        end
        @(negedge clk);
        dado_valido = 1'b0;
        do_ack();
        chk("keep_res", {28'd0, resultado_s}, 32'hE);
        chk("keep_zero", {31'd0, zero_s}, 32'd0);
        chk("keep_A", {28'd0, A_s}, 32'h3);

        // ack coinciding with a strobe: strobe dropped, next one loads A
        run_op(4'hC, 4'h3, 3'b000, 4'h0, 1'b0, 1'b1);
        @(negedge clk);
        ack = 1'b1; dado_valido = 1'b1; dado = 4'h2;
        @(negedge clk);
        ack = 1'b0; dado_valido = 1'b0;
        chk("ack_strobe_A", {28'd0, A_s}, 32'hC);
        chk("ack_strobe_valid", {31'd0, valido_s}, 32'd0);
        run_op(4'h6, 4'h1, 3'b001, 4'h7, 1'b0, 1'b0);
        do_ack();

        // Reset mid-operation in ESPERA_B, with a competing strobe
        @(negedge clk);
        dado = 4'h7; dado_valido = 1'b1;
        @(negedge clk);
        chk("preA", {28'd0, A_s}, 32'h7);
        reset = 1'b1; dado = 4'h9; dado_valido = 1'b1;
        @(negedge clk);
        reset = 1'b0; dado_valido = 1'b0;
        chk("midrst_A", {28'd0, A_s}, 32'd0);
        chk("midrst_cont", {24'd0, contador_s}, 32'd0);
        chk("midrst_ocupado", {31'd0, ocupado_s}, 32'd0);
        exp_cnt = 8'd0;
        run_op(4'h2, 4'h3, 3'b010, 4'h5, 1'b0, 1'b0);
        do_ack();

        // Counter wrap: 256 operations since reset bring contador back to 0
        for (int i = 0; i < 255; i++) begin
            run_op(4'(i), 4'h1, 3'b010, 4'(i + 1), (4'(i) == 4'hF), (4'(i) == 4'hF));
            do_ack();
        end
        chk("wrap_zero", {24'd0, contador_s}, 32'd0);
        run_op(4'hA, 4'h4, 3'b011, 4'hE, 1'b0, 1'b0);
        chk("wrap_one", {24'd0, contador_s}, 32'd1);
        do_ack();

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
